// File: rtl/ad_nios_counter_cell.sv
// Parametrised counter cell: async clear, sync clear/load, enable, carry-in,
// up/down counting with programmable modulus and selectable terminal behaviour.
module ad_nios_counter_cell #(
  parameter int unsigned      WIDTH     = 16,
  parameter longint unsigned  MODULUS   = 0,
  parameter int unsigned      TERM_MODE = 0,
  parameter longint unsigned  RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ena,
  input  logic             cin,
  input  logic             sclr,
  input  logic             sload,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             tc
);

  typedef enum logic [1:0] {
    TM_WRAP   = 2'd0,
    TM_SAT    = 2'd1,
    TM_RELOAD = 2'd2
  } term_e;

  localparam term_e            MODE = term_e'(TERM_MODE[1:0]);
  localparam logic [WIDTH-1:0] TOP  = (MODULUS == 0) ? {WIDTH{1'b1}}
                                                     : WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST  = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             w_step;
  logic             w_at_term;
  logic [WIDTH-1:0] w_load_clamp;
  logic [WIDTH-1:0] w_term_next;

  always_comb begin
    w_step       = ena & cin;
    w_at_term    = up ? (r_q == TOP) : (r_q == '0);
    w_load_clamp = (load_val > TOP) ? TOP : load_val;
    w_term_next  = r_q;
    case (MODE)
      TM_SAT:    w_term_next = r_q;
      TM_RELOAD: w_term_next = w_load_clamp;
      default:   w_term_next = up ? '0 : TOP;
    endcase
  end

  // Terminal check precedes the increment so no intermediate value passes TOP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q  <= RST;
      r_tc <= 1'b0;
    end else if (sclr) begin
      r_q  <= '0;
      r_tc <= 1'b0;
    end else if (sload) begin
      r_q  <= w_load_clamp;
      r_tc <= 1'b0;
    end else if (w_step) begin
      if (w_at_term) begin
        r_q  <= w_term_next;
        r_tc <= 1'b1;
      end else begin
        r_q  <= up ? (r_q + WIDTH'(1)) : (r_q - WIDTH'(1));
        r_tc <= 1'b0;
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign q    = r_q;
  assign tc   = r_tc;
  assign cout = w_step & w_at_term;

endmodule
